// File: rtl/flag_crossing_scheduler.sv
// rtl/flag_crossing_scheduler.sv - shares one spaced single-cycle flag channel between N_REQ requesters
// Build macro FLAG_CROSSING_SCHEDULER_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module flag_crossing_scheduler #(
  parameter int N_REQ     = 4,
  parameter int CNT_WIDTH = 4,
  parameter int GAP       = 4,
  parameter int ID_WIDTH  = $clog2(N_REQ)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic [N_REQ-1:0]    FLAG_IN,
  input  logic                CLEAR_OVERFLOW,
  output logic                FLAG_OUT,
  output logic [ID_WIDTH-1:0] FLAG_ID,
  output logic [N_REQ-1:0]    PENDING,
  output logic [N_REQ-1:0]    OVERFLOW,
  output logic                BUSY
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GUARD = 1'b1;

  // GUARD lasts GAP-1 cycles, so the down-counter is loaded with GAP-2
  localparam int              GW         = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam logic [GW-1:0]   GUARD_LOAD = (GAP > 2) ? GW'(GAP - 2) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]           state;
  logic [GW-1:0]        guard_cnt;
  logic [CNT_WIDTH-1:0] cnt [N_REQ];
  logic [ID_WIDTH-1:0]  winner;
  logic                 found;
  logic                 grant;
  logic [N_REQ-1:0]     dec_vec;
  logic [N_REQ-1:0]     ovf_set;

`ifndef FLAG_CROSSING_SCHEDULER_FIXED_PRIO_EN
  logic [ID_WIDTH-1:0]  rr_ptr;
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      PENDING[i] = (cnt[i] != '0);
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef FLAG_CROSSING_SCHEDULER_FIXED_PRIO_EN
      if (!found && PENDING[k]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(k);
      end
`else
      if (!found && PENDING[(int'(rr_ptr) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_WIDTH'((int'(rr_ptr) + k) % N_REQ);
      end
`endif
    end
  end

  assign grant = (state == ST_IDLE) && ENABLE && found;
  assign BUSY  = (|PENDING) || (state == ST_GUARD);

  always_comb begin
    dec_vec = '0;
    ovf_set = '0;
    for (int i = 0; i < N_REQ; i++) begin
      dec_vec[i] = grant && (winner == ID_WIDTH'(i));
      ovf_set[i] = FLAG_IN[i] && !dec_vec[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
      OVERFLOW <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (FLAG_IN[i] && !dec_vec[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !FLAG_IN[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      // a drop in the same cycle as a clear keeps the sticky bit set
      OVERFLOW <= ovf_set | (OVERFLOW & ~{N_REQ{CLEAR_OVERFLOW}});
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      guard_cnt <= '0;
      FLAG_OUT  <= 1'b0;
      FLAG_ID   <= '0;
`ifndef FLAG_CROSSING_SCHEDULER_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      FLAG_OUT <= grant;
      if (grant) begin
        FLAG_ID <= winner;
`ifndef FLAG_CROSSING_SCHEDULER_FIXED_PRIO_EN
        rr_ptr  <= ID_WIDTH'((int'(winner) + 1) % N_REQ);
`endif
      end
      case (state)
        ST_IDLE: begin
          if (grant && (GAP > 1)) begin
            state     <= ST_GUARD;
            guard_cnt <= GUARD_LOAD;
          end
        end
        ST_GUARD: begin
          if (guard_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_crossing_scheduler.sv
// tb/tb_flag_crossing_scheduler.sv - directed self-checking bench for flag_crossing_scheduler
module tb_flag_crossing_scheduler;

  logic       CLK            = 1'b0;
  logic       RST_N          = 1'b0;
  logic       ENABLE         = 1'b0;
  logic       CLEAR_OVERFLOW = 1'b0;
  logic [3:0] FLAG_IN        = 4'b0000;
  logic       FLAG_OUT;
  logic [1:0] FLAG_ID;
  logic [3:0] PENDING;
  logic [3:0] OVERFLOW;
  logic       BUSY;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int pq_cyc[$];
  int pq_id[$];

  flag_crossing_scheduler #(
    .N_REQ(4), .CNT_WIDTH(4), .GAP(4), .ID_WIDTH(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FLAG_IN(FLAG_IN),
    .CLEAR_OVERFLOW(CLEAR_OVERFLOW), .FLAG_OUT(FLAG_OUT), .FLAG_ID(FLAG_ID),
    .PENDING(PENDING), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // log every issued pulse with the cycle number it is visible in
  always @(negedge CLK) begin
    if (FLAG_OUT === 1'b1) begin
      pq_cyc.push_back(cyc);
      pq_id.push_back(int'(FLAG_ID));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_log();
    pq_cyc.delete();
    pq_id.delete();
  endtask

  task automatic do_reset();
    RST_N          = 1'b0;
    FLAG_IN        = 4'b0000;
    ENABLE         = 1'b0;
    CLEAR_OVERFLOW = 1'b0;
    tick(2);
    RST_N  = 1'b1;
    ENABLE = 1'b1;
    tick();
    clear_log();
  endtask

  // n pulses expected at t0+2, t0+6, t0+10, ...
  task automatic check_train(input string tag, input int t0, input int n);
    check($sformatf("%s_count", tag), pq_cyc.size(), n);
    for (int i = 0; i < n && i < pq_cyc.size(); i++)
      check($sformatf("%s_cyc%0d", tag, i), pq_cyc[i] - t0, 2 + 4 * i);
  endtask

  initial begin
    int t0;
    int t1;
    int bad;
    int exp_ids[4];

    tick();
    check("rst_flag_out", FLAG_OUT, 0);
    check("rst_flag_id", FLAG_ID, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_pending", PENDING, 0);
    check("rst_busy", BUSY, 0);
    RST_N  = 1'b1;
    ENABLE = 1'b1;
    tick(2);

    // single flag on requester 1
    clear_log();
    t0 = cyc;
    FLAG_IN = 4'b0010;
    tick();
    FLAG_IN = 4'b0000;
    check("single_pending", PENDING, 4'b0010);
    goto(t0 + 4);
    check("single_busy_t4", BUSY, 1);
    goto(t0 + 5);
    check("single_busy_t5", BUSY, 0);
    goto(t0 + 20);
    check_train("single", t0, 1);
    if (pq_id.size() > 0) check("single_id", pq_id[0], 1);

    // three back-to-back flags on requester 0
    clear_log();
    t0 = cyc;
    FLAG_IN = 4'b0001;
    tick(3);
    FLAG_IN = 4'b0000;
    goto(t0 + 9);
    check("spacing_pending_t9", PENDING[0], 1);
    goto(t0 + 10);
    check("spacing_pending_t10", PENDING[0], 0);
    goto(t0 + 20);
    check_train("spacing", t0, 3);
    for (int i = 0; i < pq_id.size(); i++) check($sformatf("spacing_id%0d", i), pq_id[i], 0);

    // round-robin from pointer 0
    do_reset();
    t0 = cyc;
    FLAG_IN = 4'b1111;
    tick();
    FLAG_IN = 4'b0000;
    goto(t0 + 24);
    check_train("rr_all", t0, 4);
    for (int i = 0; i < pq_id.size() && i < 4; i++) check($sformatf("rr_all_id%0d", i), pq_id[i], i);

    // round-robin after last grant 1
    do_reset();
    FLAG_IN = 4'b0010;
    tick();
    FLAG_IN = 4'b0000;
    tick(10);
    clear_log();
    t0 = cyc;
    FLAG_IN = 4'b0101;
    tick();
    FLAG_IN = 4'b0000;
    goto(t0 + 16);
    check_train("rr_ptr", t0, 2);
    if (pq_id.size() > 1) begin
      check("rr_ptr_id0", pq_id[0], 2);
      check("rr_ptr_id1", pq_id[1], 0);
    end

    // saturation on requester 2 while disabled
    do_reset();
    ENABLE = 1'b0;
    FLAG_IN = 4'b0100;
    tick(17);
    FLAG_IN = 4'b0000;
    check("sat_pending", PENDING, 4'b0100);
    check("sat_overflow", OVERFLOW, 4'b0100);
    check("sat_no_pulse", pq_cyc.size(), 0);
    ENABLE = 1'b1;
    t1 = cyc;
    goto(t1 + 70);
    check("sat_pulses", pq_cyc.size(), 15);
    bad = 0;
    foreach (pq_id[i]) if (pq_id[i] != 2) bad++;
    check("sat_wrong_ids", bad, 0);
    if (pq_cyc.size() > 1) begin
      check("sat_first_lat", pq_cyc[0] - t1, 1);
      check("sat_gap", pq_cyc[1] - pq_cyc[0], 4);
    end
    check("sat_drained", PENDING, 0);
    check("sat_ovf_kept", OVERFLOW, 4'b0100);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    CLEAR_OVERFLOW = 1'b0;
    check("sat_ovf_cleared", OVERFLOW, 0);

    // set beats clear in the same cycle
    ENABLE = 1'b0;
    FLAG_IN = 4'b1000;
    tick(15);
    check("setclr_before", OVERFLOW, 0);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    CLEAR_OVERFLOW = 1'b0;
    FLAG_IN = 4'b0000;
    check("setclr_set_wins", OVERFLOW, 4'b1000);

    // increment and grant on the same edge
    do_reset();
    t0 = cyc;
    FLAG_IN = 4'b0001;
    tick(2);
    FLAG_IN = 4'b0000;
    check("incdec_flag_out", FLAG_OUT, 1);
    check("incdec_pending", PENDING, 4'b0001);
    goto(t0 + 12);
    check_train("incdec", t0, 2);

    // ENABLE dropped during GUARD
    do_reset();
    t0 = cyc;
    FLAG_IN = 4'b0011;
    tick();
    FLAG_IN = 4'b0000;
    goto(t0 + 3);
    ENABLE = 1'b0;
    goto(t0 + 12);
    check("en_guard_count", pq_cyc.size(), 1);
    check("en_guard_busy", BUSY, 1);
    ENABLE = 1'b1;
    tick();
    check("en_resume_flag", FLAG_OUT, 1);
    check("en_resume_id", FLAG_ID, 1);

    // reset while in GUARD with three pending
    do_reset();
    t0 = cyc;
    FLAG_IN = 4'b1111;
    tick();
    FLAG_IN = 4'b0000;
    goto(t0 + 3);
    check("midrst_pending_before", PENDING, 4'b1110);
    RST_N = 1'b0;
    #1;
    check("midrst_flag_out", FLAG_OUT, 0);
    check("midrst_flag_id", FLAG_ID, 0);
    check("midrst_pending", PENDING, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_overflow", OVERFLOW, 0);
    tick(2);
    clear_log();
    RST_N = 1'b1;
    tick(20);
    check("midrst_no_pulse", pq_cyc.size(), 0);

    // two 1010 flags: priority order depends on build
`ifdef FLAG_CROSSING_SCHEDULER_FIXED_PRIO_EN
    exp_ids = '{1, 1, 3, 3};
`else
    exp_ids = '{1, 3, 1, 3};
`endif
    do_reset();
    t0 = cyc;
    FLAG_IN = 4'b1010;
    tick(2);
    FLAG_IN = 4'b0000;
    goto(t0 + 20);
    check_train("prio", t0, 4);
    for (int i = 0; i < pq_id.size() && i < 4; i++) check($sformatf("prio_id%0d", i), pq_id[i], exp_ids[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
